morse_code_encoder: RTL
=======================

# morse_code_encoder

Transmit-side companion to the button-driven Morse translator. The block accepts one ASCII character per handshake and drives a single keyed output (LED or buzzer) with standard Morse timing. Dot, dash, element gap, letter gap and word gap are all derived from a parameterised unit length. It sits between a character source (UART, switches or the translator's `letter` output for loopback) and the board's indicator pin.

## Interface
- `UNIT_CYCLES`, default 4: clock cycles per Morse time unit; legal range 1 to 2^20; counter width is `$clog2(UNIT_CYCLES)+1`.
- `clk`  in  1  system clock; all logic is rising-edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `letter`  in  8  ASCII character to send; sampled only on acceptance.
- `valid`  in  1  request strobe; a character is accepted on a rising edge where `valid & ready`.
- `ready`  out  1  high only in IDLE.
- `morse_out`  out  1  keyed output; 1 = tone/LED on.
- `done`  out  1  one-cycle pulse when a character (or space) finishes, including its trailing gap.
- `err`  out  1  one-cycle pulse when an unsupported character is accepted.

## Operation
- Supported input:
  - `A`–`Z` and `a`–`z`. Lowercase maps to the same code as uppercase.
  - `0`–`9`.
  - Space (0x20).
  - All other bytes are unsupported.
- Code ROM (combinational): 3-bit length (1–5) and 5-bit pattern, sent MSB-first, where 1 = dash and 0 = dot. Examples: E = len 1 `0`; A = len 2 `01`; L = len 4 `0100`; 0 = len 5 `11111`.
- On acceptance, the block latches the length, pattern and type into registers. `letter` is don't-care afterwards.
- FSM states:
  - IDLE: `ready` = 1, `morse_out` = 0.
    - Accepting a supported letter or digit → MARK.
    - Accepting a space → WORD_GAP.
    - Accepting an unsupported byte → IDLE; `err` = 1 next cycle.
  - MARK: `morse_out` = 1 for 1 unit (dot) or 3 units (dash).
    - More elements remain → ELEM_GAP.
    - Last element sent → LETTER_GAP.
  - ELEM_GAP: `morse_out` = 0 for 1 unit, then shift the pattern, decrement the remaining count, → MARK.
  - LETTER_GAP: `morse_out` = 0 for 3 units → IDLE; `done` = 1.
  - WORD_GAP: `morse_out` = 0 for 7 units → IDLE; `done` = 1.
- Timing counters:
  - A cycle counter counts 0..UNIT_CYCLES-1.
  - A unit counter counts 0..6. The phase ends when both counters are at terminal.
- `morse_out`, `ready`, `done` and `err` are registered outputs with no combinational paths from inputs.
- `valid` while `ready` = 0 is ignored. It is not queued.

## Timing
- Reset (asserted asynchronously): state = IDLE, `ready` = 1, `morse_out` = 0, `done` = 0, `err` = 0, all counters 0. This holds even mid-character; no partial gap is emitted.
- Acceptance at edge N:
  - `ready` = 0 from cycle N+1.
  - For a letter, `morse_out` = 1 from cycle N+1.
- Busy length for a letter = (sum of element units + (n−1) + 3) × UNIT_CYCLES cycles, starting at cycle N+1.
  - In the final busy cycle+1, `done` = 1 and `ready` = 1 simultaneously.
  - Back-to-back: `valid` held high is accepted on that same edge, giving zero dead cycles between characters.
- Space: busy for 7 × UNIT_CYCLES cycles with `morse_out` = 0 throughout, then `done` pulses.
- Unsupported byte:
  - Cycle N+1: `err` = 1, `ready` = 1, `done` = 0, `morse_out` = 0.
  - A new `valid` is accepted at edge N+1.
- UNIT_CYCLES = 1 must work, meaning every phase lasts exactly its unit count in cycles.

## Test plan
- UNIT_CYCLES = 4, send `E` → `morse_out` high for 4 cycles starting N+1, low for 12, `done` pulse at N+17, `ready` high from N+17.
- Send `A`, then `l` with `valid` held → pattern `A`: 4 on / 4 off / 12 on / 12 off (32 cycles). `l` begins with no gap: 4 on, 4 off, 12 on, 4 off, 4 on, 4 off, 4 on, 12 off (48 cycles). Each character produces one `done`.
- Send `0` → five 12-cycle marks separated by 4-cycle gaps, then 12 off; 88 busy cycles total.
- Send space (0x20) → 28 cycles with `morse_out` = 0 and `ready` = 0, then a `done` pulse.
- Send `#` (0x23) → `err` pulses for 1 cycle at N+1, `morse_out` never rises, `ready` stays 1, and no `done`.
- Pulse `rst` low during the 2nd mark of `A`; pulse `valid` while busy → outputs go immediately to the reset values, and the busy `valid` is never accepted. After reset, sending `E` reproduces scenario 1 exactly.

Source files
------------

// File: rtl/morse_code_encoder.sv
// morse_code_encoder
//   Accepts one ASCII character per valid/ready handshake and keys a single
//   output with standard Morse timing derived from UNIT_CYCLES clocks per unit.
//   Ports:
//     clk       rising-edge system clock
//     rst       asynchronous active-low reset
//     letter    ASCII character, sampled only when valid & ready
//     valid     request strobe
//     ready     high only while idle
//     morse_out keyed output (1 = tone/LED on)
//     done      one-cycle pulse after a character/space and its trailing gap
//     err       one-cycle pulse after an unsupported byte is accepted
module morse_code_encoder #(
  parameter int unsigned UNIT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] letter,
  input  logic       valid,
  output logic       ready,
  output logic       morse_out,
  output logic       done,
  output logic       err
);

  localparam int unsigned CW = $clog2(UNIT_CYCLES) + 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(UNIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_MARK, S_ELEM_GAP, S_LETTER_GAP, S_WORD_GAP
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [2:0]    unit_q, unit_d;
  logic [2:0]    rem_q, rem_d;
  logic [4:0]    pat_q, pat_d;
  logic          morse_q, morse_d;
  logic          ready_q, ready_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  // Code ROM: {len[2:0], pattern[4:0]}, pattern left-aligned, 1 = dash.
  logic [7:0] up;
  logic [7:0] rom_code;
  logic       rom_ok;
  logic       rom_space;

  always_comb begin
    up = letter;
    if (letter >= 8'h61 && letter <= 8'h7A) up = letter - 8'h20;
    rom_ok    = 1'b1;
    rom_space = 1'b0;
    rom_code  = '0;
    case (up)
      8'h20: rom_space = 1'b1;
      8'h41: rom_code = {3'd2, 5'b01000}; // A
      8'h42: rom_code = {3'd4, 5'b10000}; // B
      8'h43: rom_code = {3'd4, 5'b10100}; // C
      8'h44: rom_code = {3'd3, 5'b10000}; // D
      8'h45: rom_code = {3'd1, 5'b00000}; // E
      8'h46: rom_code = {3'd4, 5'b00100}; // F
      8'h47: rom_code = {3'd3, 5'b11000}; // G
      8'h48: rom_code = {3'd4, 5'b00000}; // H
      8'h49: rom_code = {3'd2, 5'b00000}; // I
      8'h4A: rom_code = {3'd4, 5'b01110}; // J
      8'h4B: rom_code = {3'd3, 5'b10100}; // K
      8'h4C: rom_code = {3'd4, 5'b01000}; // L
      8'h4D: rom_code = {3'd2, 5'b11000}; // M
      8'h4E: rom_code = {3'd2, 5'b10000}; // N
      8'h4F: rom_code = {3'd3, 5'b11100}; // O
      8'h50: rom_code = {3'd4, 5'b01100}; // P
      8'h51: rom_code = {3'd4, 5'b11010}; // Q
      8'h52: rom_code = {3'd3, 5'b01000}; // R
      8'h53: rom_code = {3'd3, 5'b00000}; // S
      8'h54: rom_code = {3'd1, 5'b10000}; // T
      8'h55: rom_code = {3'd3, 5'b00100}; // U
      8'h56: rom_code = {3'd4, 5'b00010}; // V
      8'h57: rom_code = {3'd3, 5'b01100}; // W
      8'h58: rom_code = {3'd4, 5'b10010}; // X
      8'h59: rom_code = {3'd4, 5'b10110}; // Y
      8'h5A: rom_code = {3'd4, 5'b11000}; // Z
      8'h30: rom_code = {3'd5, 5'b11111};
      8'h31: rom_code = {3'd5, 5'b01111};
      8'h32: rom_code = {3'd5, 5'b00111};
      8'h33: rom_code = {3'd5, 5'b00011};
      8'h34: rom_code = {3'd5, 5'b00001};
      8'h35: rom_code = {3'd5, 5'b00000};
      8'h36: rom_code = {3'd5, 5'b10000};
      8'h37: rom_code = {3'd5, 5'b11000};
      8'h38: rom_code = {3'd5, 5'b11100};
      8'h39: rom_code = {3'd5, 5'b11110};
      default: rom_ok = 1'b0;
    endcase
  end

  logic [2:0] phase_units;
  logic       last_cyc;
  logic       phase_end;
  logic       accept;

  always_comb begin
    case (state_q)
      S_MARK:       phase_units = pat_q[4] ? 3'd3 : 3'd1;
      S_LETTER_GAP: phase_units = 3'd3;
      S_WORD_GAP:   phase_units = 3'd7;
      default:      phase_units = 3'd1;
    endcase
  end

  assign last_cyc  = (cyc_q == CYC_LAST);
  assign phase_end = last_cyc && (unit_q == phase_units - 3'd1);
  // ready_q is high exactly when state_q is IDLE.
  assign accept    = ready_q & valid;

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    unit_d  = unit_q;
    rem_d   = rem_q;
    pat_d   = pat_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (rom_space) begin
            state_d = S_WORD_GAP;
          end else if (rom_ok) begin
            state_d = S_MARK;
            rem_d   = rom_code[7:5];
            pat_d   = rom_code[4:0];
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_MARK: begin
        if (phase_end) state_d = (rem_q == 3'd1) ? S_LETTER_GAP : S_ELEM_GAP;
      end
      S_ELEM_GAP: begin
        if (phase_end) begin
          state_d = S_MARK;
          pat_d   = pat_q << 1;
          rem_d   = rem_q - 3'd1;
        end
      end
      S_LETTER_GAP, S_WORD_GAP: begin
        if (phase_end) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Counters free-run inside a phase and wrap to zero at its end, so each
    // new phase starts from zero without an explicit clear.
    if (state_q != S_IDLE) begin
      if (last_cyc) begin
        cyc_d  = '0;
        unit_d = phase_end ? 3'd0 : unit_q + 3'd1;
      end else begin
        cyc_d = cyc_q + 1'b1;
      end
    end

    // Outputs are registered from the next state so they align with it.
    morse_d = (state_d == S_MARK);
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      unit_q  <= '0;
      rem_q   <= '0;
      pat_q   <= '0;
      morse_q <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      unit_q  <= unit_d;
      rem_q   <= rem_d;
      pat_q   <= pat_d;
      morse_q <= morse_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign ready     = ready_q;
  assign morse_out = morse_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
